// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared register-file widths, writeback request struct and source select enum
package rv_core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_SRC_IDLE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - writeback arbiter bus bundle; forwarding signals exist only with WB_FWD_EN
interface wb_write_arbiter_if;
    import rv_core_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  ldu_valid;
    logic [REG_ADDR_W-1:0] ldu_rd;
    logic [XLEN-1:0]       ldu_data;
    logic                  ldu_ready;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  stall;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_din;
    logic [3:0]            fifo_count;
    logic                  drain_req;
`ifdef WB_FWD_EN
    logic                  rs1_fwd_hit;
    logic [XLEN-1:0]       rs1_fwd_data;
    logic                  rs2_fwd_hit;
    logic [XLEN-1:0]       rs2_fwd_data;
`endif

    modport master (
`ifdef WB_FWD_EN
        input  rs1_fwd_hit, rs1_fwd_data, rs2_fwd_hit, rs2_fwd_data,
`endif
        output alu_valid, alu_rd, alu_data,
        output ldu_valid, ldu_rd, ldu_data,
        output issue_valid, issue_rd, rs1, rs2,
        input  ldu_ready, stall, rf_we, rf_rd, rf_din, fifo_count, drain_req
    );

    modport slave (
`ifdef WB_FWD_EN
        output rs1_fwd_hit, rs1_fwd_data, rs2_fwd_hit, rs2_fwd_data,
`endif
        input  alu_valid, alu_rd, alu_data,
        input  ldu_valid, ldu_rd, ldu_data,
        input  issue_valid, issue_rd, rs1, rs2,
        output ldu_ready, stall, rf_we, rf_rd, rf_din, fifo_count, drain_req
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-result queue, power-of-two depth, extra pointer bit separates full from empty
module wb_fifo
    import rv_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  wb_req_t    push_data,
    input  logic       pop,
    output wb_req_t    head,
    output logic       full,
    output logic       empty,
    output logic [3:0] count
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t        mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    occupancy;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign occupancy = wr_ptr - rd_ptr;
    assign count     = 4'(occupancy);
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - ALU/load writeback arbiter with pending scoreboard; WB_FWD_EN adds rf forwarding
module wb_write_arbiter
    import rv_core_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_write_arbiter_if.slave bus
);

    localparam int NREGS = 1 << REG_ADDR_W;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  alu_win;
    wb_req_t               push_req;
    wb_req_t               head;
    wb_req_t               sel;
    wb_src_e               src;
    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      pending_nxt;
    logic [1:0]            drain_cnt;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_rd_q;
    logic [XLEN-1:0]       rf_din_q;

    assign bus.ldu_ready = !fifo_full && !reset;
    // Results for x0 are accepted but never enqueued.
    assign push     = bus.ldu_valid && bus.ldu_ready && (bus.ldu_rd != REG_ZERO);
    assign push_req = '{valid: 1'b1, rd: bus.ldu_rd, data: bus.ldu_data};
    assign alu_win  = bus.alu_valid && (bus.alu_rd != REG_ZERO);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (bus.fifo_count)
    );

    always_comb begin
        src = WB_SRC_IDLE;
        sel = '0;
        if (alu_win) begin
            src = WB_SRC_ALU;
            sel = '{valid: 1'b1, rd: bus.alu_rd, data: bus.alu_data};
        end else if (!fifo_empty) begin
            src = WB_SRC_FIFO;
            sel = head;
        end
    end

    assign pop = (src == WB_SRC_FIFO) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q  <= 1'b0;
            rf_rd_q  <= '0;
            rf_din_q <= '0;
        end else begin
            rf_we_q <= sel.valid;
            if (sel.valid) begin
                rf_rd_q  <= sel.rd;
                rf_din_q <= sel.data;
            end
        end
    end

    assign bus.rf_we  = rf_we_q;
    assign bus.rf_rd  = rf_rd_q;
    assign bus.rf_din = rf_din_q;

    // Clear first, then set, so a fresh issue to the same rd survives the pop.
    always_comb begin
        pending_nxt = pending;
        if (pop) pending_nxt[head.rd] = 1'b0;
        if (bus.issue_valid && (bus.issue_rd != REG_ZERO)) pending_nxt[bus.issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) pending <= '0;
        else       pending <= pending_nxt;
    end

    assign bus.stall = ((bus.rs1 != REG_ZERO) && pending[bus.rs1]) ||
                       ((bus.rs2 != REG_ZERO) && pending[bus.rs2]);

    // Counts ALU wins that starve a non-empty queue; saturates at 3.
    always_ff @(posedge clk) begin
        if (reset || pop || fifo_empty) drain_cnt <= 2'd0;
        else if (alu_win && (drain_cnt != 2'd3)) drain_cnt <= drain_cnt + 2'd1;
    end

    assign bus.drain_req = (drain_cnt == 2'd3);

`ifdef WB_FWD_EN
    always_comb begin
        bus.rs1_fwd_hit  = 1'b0;
        bus.rs1_fwd_data = '0;
        bus.rs2_fwd_hit  = 1'b0;
        bus.rs2_fwd_data = '0;
        if (rf_we_q && (rf_rd_q == bus.rs1) && (bus.rs1 != REG_ZERO)) begin
            bus.rs1_fwd_hit  = 1'b1;
            bus.rs1_fwd_data = rf_din_q;
        end
        if (rf_we_q && (rf_rd_q == bus.rs2) && (bus.rs2 != REG_ZERO)) begin
            bus.rs2_fwd_hit  = 1'b1;
            bus.rs2_fwd_data = rf_din_q;
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - directed bench for wb_write_arbiter; forwarding checks compiled with WB_FWD_EN
module tb_wb_write_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    wb_write_arbiter_if bus ();

    wb_write_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.ldu_valid   = 1'b0;
        bus.ldu_rd      = '0;
        bus.ldu_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1         = '0;
        bus.rs2         = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        chk("reset_ldu_ready", 32'(bus.ldu_ready), 32'd0);
        chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
        chk("reset_rf_rd", 32'(bus.rf_rd), 32'd0);
        chk("reset_rf_din", bus.rf_din, 32'd0);
        chk("reset_count", 32'(bus.fifo_count), 32'd0);
        chk("reset_drain", 32'(bus.drain_req), 32'd0);
        chk("reset_stall", 32'(bus.stall), 32'd0);
        reset = 1'b0;
        step();

        // ALU only
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h0000_A5A5;
        step();
        chk("alu_rf_we", 32'(bus.rf_we), 32'd1);
        chk("alu_rf_rd", 32'(bus.rf_rd), 32'd5);
        chk("alu_rf_din", bus.rf_din, 32'h0000_A5A5);
`ifdef WB_FWD_EN
        bus.rs1 = 5'd5; bus.rs2 = 5'd6;
        #1;
        chk("fwd_rs1_hit", 32'(bus.rs1_fwd_hit), 32'd1);
        chk("fwd_rs1_data", bus.rs1_fwd_data, 32'h0000_A5A5);
        chk("fwd_rs2_hit", 32'(bus.rs2_fwd_hit), 32'd0);
        chk("fwd_rs2_data", bus.rs2_fwd_data, 32'd0);
`endif
        idle();
        step();
        chk("idle_rf_we", 32'(bus.rf_we), 32'd0);

        // Load hazard on x7
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        step();
        idle();
        bus.rs1 = 5'd7;
        #1;
        chk("ld_stall_pending", 32'(bus.stall), 32'd1);
        bus.ldu_valid = 1'b1; bus.ldu_rd = 5'd7; bus.ldu_data = 32'h0000_1234;
        #1;
        chk("ld_ready", 32'(bus.ldu_ready), 32'd1);
        step();
        bus.ldu_valid = 1'b0;
        #1;
        chk("ld_stall_queued", 32'(bus.stall), 32'd1);
        chk("ld_count1", 32'(bus.fifo_count), 32'd1);
        chk("ld_rf_we_wait", 32'(bus.rf_we), 32'd0);
        step();
        chk("ld_rf_we", 32'(bus.rf_we), 32'd1);
        chk("ld_rf_rd", 32'(bus.rf_rd), 32'd7);
        chk("ld_rf_din", bus.rf_din, 32'h0000_1234);
        chk("ld_stall_clear", 32'(bus.stall), 32'd0);
        chk("ld_count0", 32'(bus.fifo_count), 32'd0);
        idle();
        step();

        // Fill queue while ALU keeps winning
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1;
        for (int k = 0; k < 4; k++) begin
            bus.alu_data  = 32'hAA0 + 32'(k);
            bus.ldu_valid = 1'b1;
            bus.ldu_rd    = 5'(10 + k);
            bus.ldu_data  = 32'h100 + 32'(k);
            #1;
            chk($sformatf("fill_ready_%0d", k), 32'(bus.ldu_ready), 32'd1);
            step();
            chk($sformatf("fill_count_%0d", k), 32'(bus.fifo_count), 32'(k + 1));
            chk($sformatf("fill_drain_%0d", k), 32'(bus.drain_req), (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("fill_rf_din_%0d", k), bus.rf_din, 32'hAA0 + 32'(k));
        end
        bus.alu_data = 32'hAA4; bus.ldu_rd = 5'd14; bus.ldu_data = 32'h104;
        #1;
        chk("full_ready", 32'(bus.ldu_ready), 32'd0);
        step();
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        chk("full_drain_sat", 32'(bus.drain_req), 32'd1);
        chk("full_rf_rd", 32'(bus.rf_rd), 32'd1);
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("drain_rf_we_%0d", k), 32'(bus.rf_we), 32'd1);
            chk($sformatf("drain_rf_rd_%0d", k), 32'(bus.rf_rd), 32'(10 + k));
            chk($sformatf("drain_rf_din_%0d", k), bus.rf_din, 32'h100 + 32'(k));
            chk($sformatf("drain_count_%0d", k), 32'(bus.fifo_count), 32'(3 - k));
            chk($sformatf("drain_req_%0d", k), 32'(bus.drain_req), 32'd0);
        end
        step();
        chk("drained_rf_we", 32'(bus.rf_we), 32'd0);

        // x0 targets are dropped
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD;
        bus.ldu_valid = 1'b1; bus.ldu_rd = 5'd0; bus.ldu_data = 32'hBEEF;
        #1;
        chk("x0_ready", 32'(bus.ldu_ready), 32'd1);
        step();
        chk("x0_rf_we_a", 32'(bus.rf_we), 32'd0);
        chk("x0_count_a", 32'(bus.fifo_count), 32'd0);
        step();
        chk("x0_rf_we_b", 32'(bus.rf_we), 32'd0);
        chk("x0_count_b", 32'(bus.fifo_count), 32'd0);
        idle();
        step();

        // Issue and pop of x9 in the same cycle
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        step();
        bus.issue_valid = 1'b0;
        bus.ldu_valid = 1'b1; bus.ldu_rd = 5'd9; bus.ldu_data = 32'h99;
        step();
        bus.ldu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        bus.rs2 = 5'd9;
        step();
        bus.issue_valid = 1'b0;
        #1;
        chk("same_rf_we", 32'(bus.rf_we), 32'd1);
        chk("same_rf_rd", 32'(bus.rf_rd), 32'd9);
        chk("same_rf_din", bus.rf_din, 32'h99);
        chk("same_stall", 32'(bus.stall), 32'd1);
        step();
        chk("same_stall_hold", 32'(bus.stall), 32'd1);

        // Reset mid-operation
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd20;
        step();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h222;
        for (int k = 0; k < 3; k++) begin
            bus.ldu_valid = 1'b1;
            bus.ldu_rd    = 5'(21 + k);
            bus.ldu_data  = 32'h200 + 32'(k);
            step();
        end
        bus.ldu_valid = 1'b0;
        bus.rs1 = 5'd20;
        #1;
        chk("pre_rst_count", 32'(bus.fifo_count), 32'd3);
        chk("pre_rst_stall", 32'(bus.stall), 32'd1);
        chk("pre_rst_rf_we", 32'(bus.rf_we), 32'd1);
        bus.alu_rd = 5'd3; bus.alu_data = 32'h333;
        reset = 1'b1;
        #1;
        chk("rst_ldu_ready", 32'(bus.ldu_ready), 32'd0);
        step();
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_din", bus.rf_din, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_drain", 32'(bus.drain_req), 32'd0);
        reset = 1'b0;
        idle();
        step();
        chk("post_rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("post_rst_count", 32'(bus.fifo_count), 32'd0);
        chk("post_rst_ready", 32'(bus.ldu_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, meaning the load-result queue depth (power of two, 2..8).
REQ-002 SHALL provide port clk  input  1  clock, all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide ports alu_valid/alu_rd/alu_data  input  1/5/32  ALU writeback request, no backpressure.
REQ-005 SHALL provide ports ldu_valid/ldu_rd/ldu_data  input  1/5/32  load/long-latency result; ldu_ready  output  1  accept.
REQ-006 SHALL provide ports issue_valid/issue_rd  input  1/5  long-latency op issued, marks rd pending.
REQ-007 SHALL provide ports rs1/rs2  input  5/5  hazard query; stall  output  1  query hits a pending register.
REQ-008 SHALL provide ports rf_we/rf_rd/rf_din  output  1/5/32  register-file write port (write_enable, rd, rd_din).
REQ-009 SHALL provide ports fifo_count  output  4  queue occupancy; drain_req  output  1  request frontend bubble.

Function
REQ-010 SHALL transfer a load result when ldu_valid && ldu_ready; ldu_ready = !full && !reset, combinational.
REQ-011 SHALL select each cycle: ALU if alu_valid && alu_rd!=0, else FIFO head if non-empty (pop), else idle.
REQ-012 SHALL register the selected write: rf_we/rf_rd/rf_din valid exactly one cycle after selection.
REQ-013 SHALL drive rf_we=0 for idle cycles and never assert rf_we with rf_rd=0.
REQ-014 SHALL accept ldu results with ldu_rd=0 and discard them without enqueuing.
REQ-015 SHALL allow push and pop in the same cycle when non-empty, count unchanged; push into empty queue is not poppable same cycle.
REQ-016 SHALL keep a 32-bit pending scoreboard: issue_valid && issue_rd!=0 sets bit; FIFO pop clears bit of popped rd.
REQ-017 SHALL give set priority over clear when issue_rd equals the popped rd in the same cycle.
REQ-018 SHALL assert stall combinationally when (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]).
REQ-019 SHALL count consecutive cycles where ALU wins while FIFO non-empty; drain_req=1 when count reaches 3.
REQ-020 SHALL clear that counter and drain_req on any FIFO pop or when FIFO empties; counter saturates at 3.
REQ-021 SHALL wrap read/write pointers modulo FIFO_DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-022 SHALL on reset clear rf_we, rf_rd, rf_din, fifo_count, pointers, pending scoreboard, drain counter, drain_req.
REQ-023 SHALL discard queued results and in-flight registered write when reset asserts mid-operation; ldu_ready=0 while reset.

Configuration
REQ-024 SHALL, with WB_FWD_EN defined, add outputs rs1_fwd_hit/rs1_fwd_data, rs2_fwd_hit/rs2_fwd_data (1/32 each).
REQ-025 SHALL set rsN_fwd_hit=1 when rf_we && rf_rd==rsN && rsN!=0, with rsN_fwd_data=rf_din, else hit 0, data 0.
REQ-026 SHALL, without WB_FWD_EN, omit those ports and logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL place REG_ADDR_W=5, XLEN=32, REG_ZERO=0 and a wb_req struct (valid, rd, data) in shared package rv_core_pkg.
REQ-028 SHALL implement the queue as sub-module wb_fifo (parameterised depth, push/pop/full/empty/count).

Verification
REQ-029 SHALL cover: ALU only, alu_valid=1 rd=5 data=0xA5A5 -> next cycle rf_we=1 rf_rd=5 rf_din=0xA5A5.
REQ-030 SHALL cover: issue rd=7, then ldu rd=7 data=0x1234 with alu idle -> stall for rs1=7 until pop; rf write x7=0x1234 two cycles after accept.
REQ-031 SHALL cover: 4 ldu pushes with ALU valid every cycle -> ldu_ready=0 at count 4, drain_req=1 after 3 ALU wins, ALU idle drains in order.
REQ-032 SHALL cover: alu_rd=0 and ldu_rd=0 requests -> rf_we never asserted, fifo_count stays 0.
REQ-033 SHALL cover: same cycle issue rd=9 and pop rd=9 -> pending[9] remains 1, stall asserted for rs2=9.
REQ-034 SHALL cover: reset with count=3 and pending bits set -> count 0, stall 0, rf_we 0 next cycle; with WB_FWD_EN, rs1=rf_rd hit returns rf_din.
